// File: rtl/vga_bus_pipe.sv
// Fixed-latency register pipeline for the VGA timing/pixel bus, with optional rgb blanking
// and a frame-start pulse plus frame counter that stay aligned with the delayed bus.
module vga_bus_pipe #(
  parameter int unsigned HV_W      = 11,
  parameter int unsigned RGB_W     = 12,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned BLANK_RGB = 1,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HV_W-1:0]   in_hcount,
  input  logic [HV_W-1:0]   in_vcount,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_hblnk,
  input  logic              in_vblnk,
  input  logic [RGB_W-1:0]  in_rgb,
  output logic [HV_W-1:0]   out_hcount,
  output logic [HV_W-1:0]   out_vcount,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_hblnk,
  output logic              out_vblnk,
  output logic [RGB_W-1:0]  out_rgb,
  output logic              out_frame_start,
  output logic [FCNT_W-1:0] out_frame_cnt
);

  // Bus word: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, sof}
  localparam int unsigned BusW = 2 * HV_W + RGB_W + 5;

  logic [BusW-1:0]   stage_q [DEPTH];
  logic [BusW-1:0]   bus_in;
  logic [BusW-1:0]   bus_out;
  logic [RGB_W-1:0]  rgb_raw;
  logic              prev_zero_q;
  logic              in_zero;
  logic              sof;
  logic [FCNT_W-1:0] frame_cnt_q;

  assign in_zero = (in_hcount == '0) && (in_vcount == '0);
  // Only the first cycle of a run of (0,0) inputs starts a frame.
  assign sof     = in_zero && !prev_zero_q;
  assign bus_in  = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb, sof};

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_zero_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      prev_zero_q <= in_zero;
      stage_q[0]  <= bus_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus_out = stage_q[DEPTH-1];
  assign {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, rgb_raw,
          out_frame_start} = bus_out;

  always_comb begin
    out_rgb = rgb_raw;
    if ((BLANK_RGB != 0) && (out_hblnk || out_vblnk)) begin
      out_rgb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (out_frame_start) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign out_frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_bus_pipe.md
Name: vga_bus_pipe

Overview:
- Parametrised register pipeline for the VGA timing/pixel bus: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
- Inserted between the timing generator and the draw stages, and between successive draw stages, to balance latency.
- Generalises the fixed-width bus: coordinate width, colour width and delay depth are configurable.
- Adds optional rgb blanking, a frame-start pulse and a frame counter, all aligned with the delayed bus.

Parameters:
- HV_W, 11, width of hcount/vcount.
- RGB_W, 12, width of rgb.
- DEPTH, 2, pipeline stages; legal range 1..16.
- BLANK_RGB, 1, when 1, out_rgb is forced to 0 whenever out_hblnk or out_vblnk is high.
- FCNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  pixel clock; all registers on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_hcount  in  HV_W  horizontal position.
- in_vcount  in  HV_W  vertical position.
- in_hsync, in_vsync  in  1 each  sync strobes.
- in_hblnk, in_vblnk  in  1 each  blanking flags.
- in_rgb  in  RGB_W  pixel colour.
- out_hcount, out_vcount  out  HV_W  delayed counts.
- out_hsync, out_vsync, out_hblnk, out_vblnk  out  1 each  delayed flags.
- out_rgb  out  RGB_W  delayed colour, blanked per BLANK_RGB.
- out_frame_start  out  1  one-cycle pulse aligned with the first pixel (0,0) of each frame on the output side.
- out_frame_cnt  out  FCNT_W  count of frames passed.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: every stage register, out_frame_start and out_frame_cnt are cleared to 0 on the clk edge where rst=1.
  - All outputs therefore read 0 from the cycle after reset is sampled until valid data reaches the output.
- Latency: each out_* bus signal equals the corresponding in_* exactly DEPTH cycles earlier.
  - No combinational path exists from any in_* to any out_*.
- Blanking:
  - Applied at the last stage, using that stage's hblnk|vblnk.
  - With BLANK_RGB=0, rgb passes unmodified.
  - Blanking never affects the count, sync or blank outputs.
- Frame-start detection:
  - At the input, compute sof = (in_hcount==0 && in_vcount==0) && !prev_zero.
  - prev_zero is a register holding the previous cycle's (in_hcount==0 && in_vcount==0); it resets to 0.
  - sof travels down the pipeline as an extra bit, so out_frame_start is high in the same cycle out_hcount/out_vcount show (0,0).
  - Consequence: if (0,0) is held on the input for N consecutive cycles, only the first cycle produces a pulse.
  - Consequence: zeros injected by reset never produce a pulse, because the sof bits reset to 0.
- Frame counter:
  - On each clk edge where out_frame_start=1 and rst=0, out_frame_cnt increments by 1.
  - The new value is visible the cycle after the pulse.
  - Wraps from 2^FCNT_W-1 to 0 with no flag.
- Reset mid-frame:
  - Pipeline contents are discarded and the counter returns to 0.
  - After rst falls, the first DEPTH outputs are zeros.
  - The next input (0,0) following a non-(0,0) cycle produces a pulse.
  - If the input sits at (0,0) on the first post-reset cycle, it also pulses, since prev_zero=0 after reset.
- DEPTH=1: single register stage, with sof computed directly from the inputs.

Test Plan:
- Latency:
  - Stimulus: DEPTH=3; drive in_hcount=5, in_vcount=7, in_rgb=12'hABC, blnk=0 at cycle t.
  - Required: out_hcount=5, out_vcount=7, out_rgb=12'hABC at cycle t+3; values at t+1 and t+2 are unaffected.
- Blanking:
  - Stimulus: BLANK_RGB=1, in_rgb=12'hFFF with in_hblnk=1.
  - Required: out_rgb=0 while out_hcount still follows the input. Repeat with BLANK_RGB=0 -> out_rgb=12'hFFF.
- Frame start:
  - Stimulus: 800x600 timing (1056x628 total), two full frames.
  - Required: out_frame_start is high for exactly one cycle per frame, coincident with out (0,0); out_frame_cnt reads 1 and then 2.
- Held (0,0) and wrap:
  - Stimulus: hold in (0,0) for 4 cycles.
  - Required: one pulse only.
  - Stimulus: with FCNT_W=2, run 4 frames.
  - Required: counter sequence 1,2,3,0.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle mid-line with DEPTH=2.
  - Required: next 2 output cycles are all-zero with no frame pulse; out_frame_cnt=0; normal delayed data resumes on the third cycle.
